pe_result_collector: RTL and testbench

- Sits directly downstream of the PE group output port and consumes its accumulated-result stream (O_DataOut/O_DataOutValid/O_DataOutRdy).
- Stores a programmed number of results into a local buffer, in arrival order.
- Flags completion, then lets the NIOS II custom-instruction side read results back by index.
- Frees the PE group to start the next tile once the collector is re-armed.

---
 rtl/pe_result_collector_pkg.sv | 13 +
 rtl/pe_result_collector_result_ram.sv | 33 +++
 rtl/pe_result_collector.sv | 93 +++++++++
 tb/tb_pe_result_collector.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_result_collector_pkg.sv
// pe_result_collector_pkg: state encodings and default widths shared with the PE group.
package pe_result_collector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam int DATA_WIDTH   = 32;
    localparam int BUFFER_WIDTH = 4;

endpackage

// File: rtl/pe_result_collector_result_ram.sv
// pe_result_collector_result_ram: simple dual-port result buffer, sync write, registered read.
module pe_result_collector_result_ram #(
    parameter int DataWidth   = 32,
    parameter int BufferWidth = 4,
    parameter int BufferSize  = 2 ** BufferWidth
) (
    input  logic                   clk,
    input  logic                   aclr,
    input  logic                   clk_en,
    input  logic                   wr_en,
    input  logic [BufferWidth-1:0] wr_addr,
    input  logic [DataWidth-1:0]   wr_data,
    input  logic                   rd_en,
    input  logic [BufferWidth-1:0] rd_addr,
    output logic [DataWidth-1:0]   rd_data
);

    logic [DataWidth-1:0] mem [BufferSize];
    logic [DataWidth-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk)
        if (clk_en && wr_en) mem[wr_addr] <= wr_data;

    // Non-blocking update of mem means a same-address read sees the old word.
    always_comb rd_data_d = rd_en ? mem[rd_addr] : rd_data_q;

    always_ff @(posedge clk or negedge aclr)
        if (!aclr) rd_data_q <= '0;
        else if (clk_en) rd_data_q <= rd_data_d;

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pe_result_collector.sv
// pe_result_collector: buffers a programmed number of PE group results and serves indexed reads.
module pe_result_collector
    import pe_result_collector_pkg::*;
#(
    parameter int DataWidth   = DATA_WIDTH,
    parameter int BufferWidth = BUFFER_WIDTH,
    parameter int BufferSize  = 2 ** BufferWidth
) (
    input  logic                   clk,
    input  logic                   aclr,
    input  logic                   clk_en,
    input  logic                   Start,
    input  logic [BufferWidth:0]   Result_Count,
    input  logic                   O_DataInValid,
    output logic                   O_DataInRdy,
    input  logic [DataWidth-1:0]   O_DataIn,
    input  logic                   Rd_En,
    input  logic [BufferWidth-1:0] Rd_Addr,
    output logic [DataWidth-1:0]   Rd_Data,
    output logic                   Rd_DataValid,
    output logic                   Done,
    output logic                   Err,
    output logic [BufferWidth:0]   Stored_Count
);

    localparam logic [BufferWidth:0] SizeW = (BufferWidth + 1)'(BufferSize);

    state_e               state_q, state_d;
    logic [BufferWidth:0] cnt_q, cnt_d, target_q, target_d, cnt_inc;
    logic                 err_q, err_d, rd_valid_q, rd_valid_d;
    logic                 hs;

    // Start wins over a same-cycle handshake, so the colliding word is dropped.
    assign hs      = clk_en && !Start && state_q == COLLECT && O_DataInValid;
    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge aclr)
        if (!aclr) state_q <= IDLE;
        else if (clk_en) state_q <= state_d;

    always_comb begin
        state_d = state_q;
        if (Start) state_d = (Result_Count == '0) ? DONE : COLLECT;
        else if (hs && cnt_inc == target_q) state_d = DONE;
    end

    always_comb begin
        O_DataInRdy = state_q == COLLECT;
        Done        = state_q == DONE;
    end

    always_comb begin
        cnt_d      = Start ? '0 : hs ? cnt_inc : cnt_q;
        target_d   = Start ? ((Result_Count > SizeW) ? SizeW : Result_Count) : target_q;
        err_d      = Start ? (Result_Count > SizeW) : err_q;
        rd_valid_d = Rd_En;
    end

    always_ff @(posedge clk or negedge aclr)
        if (!aclr) begin
            cnt_q      <= '0;
            target_q   <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else if (clk_en) begin
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
        end

    assign Err          = err_q;
    assign Stored_Count = cnt_q;
    assign Rd_DataValid = rd_valid_q;

    // Write pointer is the low bits of the count; it never wraps since target <= BufferSize.
    pe_result_collector_result_ram #(
        .DataWidth  (DataWidth),
        .BufferWidth(BufferWidth),
        .BufferSize (BufferSize)
    ) result_ram (
        .clk    (clk),
        .aclr   (aclr),
        .clk_en (clk_en),
        .wr_en  (hs),
        .wr_addr(cnt_q[BufferWidth-1:0]),
        .wr_data(O_DataIn),
        .rd_en  (Rd_En),
        .rd_addr(Rd_Addr),
        .rd_data(Rd_Data)
    );

endmodule

// File: tb/tb_pe_result_collector.sv
// tb_pe_result_collector: table-driven directed vectors plus hand sequences for overflow and reset.
module tb_pe_result_collector;

    logic        clk = 1'b0;
    logic        aclr, clk_en, start, valid, rdy, rd_en, rd_valid, done, err;
    logic [4:0]  result_count, stored_count;
    logic [31:0] din, rd_data;
    logic [3:0]  rd_addr;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        start;
        logic [4:0]  rc;
        logic        v;
        logic [31:0] din;
        logic        re;
        logic [3:0]  ra;
        logic        ce;
        logic        rdy;
        logic        done;
        logic        err;
        logic [4:0]  cnt;
        logic        rdv;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    pe_result_collector dut (
        .clk          (clk),
        .aclr         (aclr),
        .clk_en       (clk_en),
        .Start        (start),
        .Result_Count (result_count),
        .O_DataInValid(valid),
        .O_DataInRdy  (rdy),
        .O_DataIn     (din),
        .Rd_En        (rd_en),
        .Rd_Addr      (rd_addr),
        .Rd_Data      (rd_data),
        .Rd_DataValid (rd_valid),
        .Done         (done),
        .Err          (err),
        .Stored_Count (stored_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(int s, int rc, int v, int d, int re, int ra, int ce,
                                int erdy, int edone, int eerr, int ecnt, int erdv, int erd);
        vec_t t;
        t.start = s[0]; t.rc = rc[4:0]; t.v = v[0]; t.din = d; t.re = re[0]; t.ra = ra[3:0];
        t.ce = ce[0]; t.rdy = erdy[0]; t.done = edone[0]; t.err = eerr[0]; t.cnt = ecnt[4:0];
        t.rdv = erdv[0]; t.rd = erd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input int rc, input logic v, input int d,
                         input logic re, input int ra, input logic ce);
        start = s; result_count = rc[4:0]; valid = v; din = d; rd_en = re; rd_addr = ra[3:0]; clk_en = ce;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input logic erdy, input logic edone,
                              input logic eerr, input int ecnt);
        chk({tag, " rdy"}, 32'(rdy), 32'(erdy));
        chk({tag, " done"}, 32'(done), 32'(edone));
        chk({tag, " err"}, 32'(err), 32'(eerr));
        chk({tag, " cnt"}, 32'(stored_count), ecnt);
    endtask

    initial begin
        // Basic collection then reads
        tbl.push_back(mk(1,4,0,0, 0,0,1, 1,0,0,0, 0,0));
        tbl.push_back(mk(0,0,1,10,0,0,1, 1,0,0,1, 0,0));
        tbl.push_back(mk(0,0,1,20,0,0,1, 1,0,0,2, 0,0));
        tbl.push_back(mk(0,0,1,30,0,0,1, 1,0,0,3, 0,0));
        tbl.push_back(mk(0,0,1,40,0,0,1, 0,1,0,4, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,0,1, 0,1,0,4, 1,10));
        tbl.push_back(mk(0,0,0,0, 1,1,1, 0,1,0,4, 1,20));
        tbl.push_back(mk(0,0,0,0, 1,2,1, 0,1,0,4, 1,30));
        tbl.push_back(mk(0,0,0,0, 1,3,1, 0,1,0,4, 1,40));
        tbl.push_back(mk(0,0,0,0, 0,0,1, 0,1,0,4, 0,0));
        // Backpressure: third word stays pending
        tbl.push_back(mk(1,2,0,0, 0,0,1, 1,0,0,0, 0,0));
        tbl.push_back(mk(0,0,1,50,0,0,1, 1,0,0,1, 0,0));
        tbl.push_back(mk(0,0,1,60,0,0,1, 0,1,0,2, 0,0));
        tbl.push_back(mk(0,0,1,70,0,0,1, 0,1,0,2, 0,0));
        tbl.push_back(mk(0,0,1,70,1,0,1, 0,1,0,2, 1,50));
        tbl.push_back(mk(0,0,1,70,1,1,1, 0,1,0,2, 1,60));
        tbl.push_back(mk(0,0,0,0, 1,2,1, 0,1,0,2, 1,30));
        // Zero count
        tbl.push_back(mk(1,0,0,0, 0,0,1, 0,1,0,0, 0,0));
        tbl.push_back(mk(0,0,1,99,0,0,1, 0,1,0,0, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,0,1, 0,1,0,0, 1,50));
        // Restart collision
        tbl.push_back(mk(1,5,0,0, 0,0,1, 1,0,0,0, 0,0));
        tbl.push_back(mk(0,0,1,1, 0,0,1, 1,0,0,1, 0,0));
        tbl.push_back(mk(0,0,1,2, 0,0,1, 1,0,0,2, 0,0));
        tbl.push_back(mk(1,5,1,3, 0,0,1, 1,0,0,0, 0,0));
        tbl.push_back(mk(0,0,1,4, 0,0,1, 1,0,0,1, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,0,1, 1,0,0,1, 1,4));
        tbl.push_back(mk(0,0,0,0, 1,1,1, 1,0,0,1, 1,2));
        // Read/write collision returns old data
        tbl.push_back(mk(0,0,1,5, 1,1,1, 1,0,0,2, 1,2));
        tbl.push_back(mk(0,0,0,0, 1,1,1, 1,0,0,2, 1,5));
        // clk_en low freezes everything
        tbl.push_back(mk(0,0,1,6, 0,0,0, 1,0,0,2, 1,5));
        tbl.push_back(mk(0,0,1,6, 1,0,0, 1,0,0,2, 1,5));
        tbl.push_back(mk(0,0,1,6, 0,0,0, 1,0,0,2, 1,5));
        tbl.push_back(mk(0,0,1,6, 0,0,1, 1,0,0,3, 0,0));
        tbl.push_back(mk(0,0,0,0, 1,2,1, 1,0,0,3, 1,6));

        aclr = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();
        chk_status("reset", 0, 0, 0, 0);
        chk("reset rdv", 32'(rd_valid), 0);
        chk("reset rdata", rd_data, 0);
        aclr = 1'b1;
        tick();
        chk_status("idle", 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].start, int'(tbl[i].rc), tbl[i].v, int'(tbl[i].din),
                  tbl[i].re, int'(tbl[i].ra), tbl[i].ce);
            tick();
            chk_status($sformatf("row%0d", i), tbl[i].rdy, tbl[i].done, tbl[i].err, int'(tbl[i].cnt));
            chk($sformatf("row%0d rdv", i), 32'(rd_valid), 32'(tbl[i].rdv));
            if (tbl[i].rdv) chk($sformatf("row%0d rdata", i), rd_data, tbl[i].rd);
        end

        // Overflow clamp: 20 requested, 16 stored
        drive(1, 20, 0, 0, 0, 0, 1);
        tick();
        chk_status("ovf start", 1, 0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, 100 + i, 0, 0, 1);
            tick();
            chk_status($sformatf("ovf w%0d", i), i != 15, i == 15, 1, i + 1);
        end
        drive(0, 0, 1, 200, 0, 0, 1);
        tick();
        chk_status("ovf extra", 0, 1, 1, 16);
        drive(0, 0, 0, 0, 1, 15, 1);
        tick();
        chk("ovf rd15", rd_data, 115);
        drive(0, 0, 0, 0, 1, 0, 1);
        tick();
        chk("ovf rd0", rd_data, 100);
        drive(1, 3, 0, 0, 0, 0, 1);
        tick();
        chk_status("ovf clear", 1, 0, 0, 0);

        // Mid-collection asynchronous reset
        drive(0, 0, 1, 77, 0, 0, 1);
        tick();
        chk_status("rst w0", 1, 0, 0, 1);
        drive(1, 17, 0, 0, 0, 0, 1);
        tick();
        chk_status("rst start17", 1, 0, 1, 0);
        drive(0, 0, 1, 78, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 1, 0, 1);
        tick();
        chk("rst pre rdata", rd_data, 78);
        chk("rst pre rdv", 32'(rd_valid), 1);
        #2 aclr = 1'b0;
        #1;
        chk_status("rst async", 0, 0, 0, 0);
        chk("rst async rdv", 32'(rd_valid), 0);
        chk("rst async rdata", rd_data, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        aclr = 1'b1;
        drive(1, 1, 0, 0, 0, 0, 1);
        tick();
        chk_status("rst rearm", 1, 0, 0, 0);
        drive(0, 0, 1, 88, 0, 0, 1);
        tick();
        chk_status("rst w", 0, 1, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 1);
        tick();
        chk("rst rd0", rd_data, 88);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
